// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: prescaler, run/pause/adjust FSM and 4-digit BCD count.
// Optional BLINK_EN macro adds the adjust-mode blink phase driving blink_mask.
module stopwatch_counter #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause_p,
  input  logic        adj,
  input  logic        sel,
  output logic [15:0] bcd_out,
  output logic [3:0]  blink_mask,
  output logic [1:0]  state_out
);
  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {PAUSED = 2'b00, RUN = 2'b01, ADJUST = 2'b10} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sec_ones_q, sec_ones_d, sec_tens_q, sec_tens_d;
  logic [3:0]    min_ones_q, min_ones_d, min_tens_q, min_tens_d;
  logic          tick_1hz, tick_2hz;
  logic          run_step, inc_sec, inc_min, sec_wrap;

  assign tick_1hz = (cnt_q == CW'(TICK_DIV - 1));
  assign tick_2hz = tick_1hz || (cnt_q == CW'(TICK_DIV / 2 - 1));

  always_comb begin
    cnt_d = tick_1hz ? '0 : cnt_q + CW'(1);
  end

  always_comb begin
    state_d = state_q;
    if (adj) begin
      state_d = ADJUST;
    end else begin
      case (state_q)
        ADJUST:  state_d = PAUSED;
        PAUSED:  if (pause_p) state_d = RUN;
        RUN:     if (pause_p) state_d = PAUSED;
        default: state_d = PAUSED;
      endcase
    end
  end

  // Ticks act on the current state; a simultaneous state change lands next cycle.
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    sec_wrap   = 1'b0;
    run_step   = (state_q == RUN) && tick_1hz;
    inc_sec    = run_step || ((state_q == ADJUST) && tick_2hz && sel);

    if (inc_sec) begin
      if (sec_ones_q == 4'd9) begin
        sec_ones_d = 4'd0;
        if (sec_tens_q == 4'd5) begin
          sec_tens_d = 4'd0;
          sec_wrap   = 1'b1;
        end else begin
          sec_tens_d = sec_tens_q + 4'd1;
        end
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end

    inc_min = (run_step && sec_wrap) || ((state_q == ADJUST) && tick_2hz && !sel);
    if (inc_min) begin
      if (min_ones_q == 4'd9) begin
        min_ones_d = 4'd0;
        min_tens_d = (min_tens_q == 4'd5) ? 4'd0 : min_tens_q + 4'd1;
      end else begin
        min_ones_d = min_ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PAUSED;
      cnt_q      <= '0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
    end
  end

  assign bcd_out   = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
  assign state_out = state_q;

`ifdef BLINK_EN
  logic       phase_q, phase_d;
  logic [3:0] mask_q, mask_d;

  // Phase is held at 0 outside ADJUST so every entry starts unblanked.
  always_comb begin
    phase_d = phase_q;
    if (state_d != ADJUST || state_q != ADJUST) begin
      phase_d = 1'b0;
    end else if (tick_2hz) begin
      phase_d = ~phase_q;
    end
    mask_d = phase_d ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      mask_q  <= 4'b0000;
    end else begin
      phase_q <= phase_d;
      mask_q  <= mask_d;
    end
  end

  assign blink_mask = mask_q;
`else
  assign blink_mask = 4'b0000;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with TICK_DIV=4; a local prescaler
// model tells the stimulus which clock edges carry tick_1hz / tick_2hz.
module tb_stopwatch_counter;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst, pause_p, adj, sel;
  logic [15:0] bcd_out;
  logic [3:0]  blink_mask;
  logic [1:0]  state_out;
  int          tests = 0;
  int          fails = 0;
  int          tb_cnt;

  stopwatch_counter #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .pause_p(pause_p), .adj(adj), .sel(sel),
    .bcd_out(bcd_out), .blink_mask(blink_mask), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Value the DUT prescaler holds going into the next rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt + 1) % TD;
  end

  task automatic wait_cnt(input int v);
    int n = 0;
    while (tb_cnt != v && n < 8) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (tb_cnt != v) begin
      fails++;
      $display("FAIL wait_cnt: prescaler phase %0d, required %0d", tb_cnt, v);
    end
  endtask

  task automatic pulse_pause();
    pause_p = 1'b1;
    @(negedge clk);
    pause_p = 1'b0;
  endtask

  // Hold adjust with the given field and let n tick_2hz edges pass.
  task automatic adj_ticks(input logic s, input int n);
    adj = 1'b1;
    sel = s;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      if (!(tb_cnt == 1 || tb_cnt == 3)) @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pause_p = 1'b0; adj = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if (bcd_out !== 16'h0000) begin fails++; $display("FAIL reset_bcd: got %h, expected 0000", bcd_out); end
    tests++;
    if (state_out !== 2'b00) begin fails++; $display("FAIL reset_state: got %b, expected 00", state_out); end
    tests++;
    if (blink_mask !== 4'b0000) begin fails++; $display("FAIL reset_mask: got %b, expected 0000", blink_mask); end
  endtask

  task automatic test_run();
    wait_cnt(0);
    pulse_pause();
    tests++;
    if (state_out !== 2'b01) begin fails++; $display("FAIL run_state: got %b, expected 01", state_out); end
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      if (i == 36) begin
        tests++;
        if (bcd_out !== 16'h0009) begin fails++; $display("FAIL run_0009: got %h, expected 0009", bcd_out); end
      end
      if (i == 40) begin
        tests++;
        if (bcd_out !== 16'h0010) begin fails++; $display("FAIL run_carry_0010: got %h, expected 0010", bcd_out); end
      end
    end
    tests++;
    if (bcd_out !== 16'h0100) begin fails++; $display("FAIL run_0100: got %h, expected 0100", bcd_out); end
    pulse_pause();
    tests++;
    if (state_out !== 2'b00) begin fails++; $display("FAIL pause_state: got %b, expected 00", state_out); end
    tests++;
    if (bcd_out !== 16'h0100) begin fails++; $display("FAIL pause_hold: got %h, expected 0100", bcd_out); end
  endtask

  task automatic test_wrap();
    adj_ticks(1'b0, 58);
    tests++;
    if (bcd_out !== 16'h5900) begin fails++; $display("FAIL adj_min_59: got %h, expected 5900", bcd_out); end
    adj_ticks(1'b1, 59);
    tests++;
    if (bcd_out !== 16'h5959) begin fails++; $display("FAIL adj_sec_59: got %h, expected 5959", bcd_out); end
    adj = 1'b0;
    @(negedge clk);
    tests++;
    if (state_out !== 2'b00) begin fails++; $display("FAIL adj_exit_state: got %b, expected 00", state_out); end
    wait_cnt(0);
    pulse_pause();
    repeat (2) @(negedge clk);
    tests++;
    if (bcd_out !== 16'h5959) begin fails++; $display("FAIL wrap_pre: got %h, expected 5959", bcd_out); end
    @(negedge clk);
    tests++;
    if (bcd_out !== 16'h0000) begin fails++; $display("FAIL wrap_5959: got %h, expected 0000", bcd_out); end
  endtask

  task automatic test_pause_on_tick();
    wait_cnt(3);
    pulse_pause();
    tests++;
    if (bcd_out !== 16'h0001) begin fails++; $display("FAIL tick_pause_inc: got %h, expected 0001", bcd_out); end
    tests++;
    if (state_out !== 2'b00) begin fails++; $display("FAIL tick_pause_state: got %b, expected 00", state_out); end
    repeat (8) @(negedge clk);
    tests++;
    if (bcd_out !== 16'h0001) begin fails++; $display("FAIL tick_pause_frozen: got %h, expected 0001", bcd_out); end
  endtask

  task automatic test_adj_sec();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0059; exp_seq[1] = 16'h0000; exp_seq[2] = 16'h0001;
    adj_ticks(1'b1, 57);
    tests++;
    if (bcd_out !== 16'h0058) begin fails++; $display("FAIL adj_sec_58: got %h, expected 0058", bcd_out); end
    for (int k = 0; k < 3; k++) begin
      adj_ticks(1'b1, 1);
      tests++;
      if (bcd_out !== exp_seq[k]) begin
        fails++;
        $display("FAIL adj_sec_step%0d: got %h, expected %h", k, bcd_out, exp_seq[k]);
      end
    end
    adj = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_blink();
    logic [3:0] exp_mask;
    adj = 1'b1;
    sel = 1'b0;
    @(negedge clk);
    tests++;
    if (blink_mask !== 4'b0000) begin fails++; $display("FAIL blink_entry: got %b, expected 0000", blink_mask); end
    for (int k = 1; k <= 4; k++) begin
      if (!(tb_cnt == 1 || tb_cnt == 3)) @(negedge clk);
      @(negedge clk);
`ifdef BLINK_EN
      exp_mask = (k % 2 == 1) ? 4'b1100 : 4'b0000;
`else
      exp_mask = 4'b0000;
`endif
      tests++;
      if (blink_mask !== exp_mask) begin
        fails++;
        $display("FAIL blink_tick%0d: got %b, expected %b", k, blink_mask, exp_mask);
      end
    end
    tests++;
    if (bcd_out !== 16'h0401) begin fails++; $display("FAIL blink_min_adj: got %h, expected 0401", bcd_out); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bcd_out !== 16'h0000) begin fails++; $display("FAIL async_rst_bcd: got %h, expected 0000", bcd_out); end
    tests++;
    if (state_out !== 2'b00) begin fails++; $display("FAIL async_rst_state: got %b, expected 00", state_out); end
    tests++;
    if (blink_mask !== 4'b0000) begin fails++; $display("FAIL async_rst_mask: got %b, expected 0000", blink_mask); end
    adj = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_run();
    test_wrap();
    test_pause_on_tick();
    test_adj_sec();
    test_blink();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
